// File: rtl/sys_defs.sv
// Shared execute-stage definitions: functional-unit opcodes and default widths.
`ifndef WAYS
`define WAYS 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } ALU_FUNC;

    typedef enum logic [1:0] {
        MUL    = 2'h0,
        MULH   = 2'h1,
        MULHSU = 2'h2,
        MULHU  = 2'h3
    } MULT_FUNC;

endpackage

// File: rtl/mult_lane.sv
// One multiplier lane: slice-and-accumulate over STAGES registered stages,
// the last stage doubling as the output register.
module mult_lane
    import sys_defs::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  MULT_FUNC         in_func,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             occupied
);

    localparam int PW = 2 * XLEN;
    localparam int SW = XLEN / STAGES;

    if (!(STAGES == 1 || STAGES == 2 || STAGES == 4 || STAGES == 8) || (XLEN % STAGES) != 0) begin : g_bad_stages
        $error("mult_lane: STAGES must be 1, 2, 4 or 8 and divide XLEN");
    end

    // opa is carried already extended to the full product width, so the
    // accumulation below is plain modulo-2^PW arithmetic.
    function automatic logic [PW-1:0] extend_opa(input MULT_FUNC f, input logic [XLEN-1:0] a);
        logic s;
        s = (f != MULHU) && a[XLEN-1];
        return {{XLEN{s}}, a};
    endfunction

    function automatic logic opb_negative(input MULT_FUNC f, input logic [XLEN-1:0] b);
        return (f == MUL || f == MULH) && b[XLEN-1];
    endfunction

    function automatic logic [PW-1:0] partial(input logic [PW-1:0] a, input logic [XLEN-1:0] b, input int k);
        logic [PW-1:0] sl;
        sl = '0;
        sl[SW-1:0] = b[k*SW +: SW];
        return (a * sl) << (k * SW);
    endfunction

    logic              vld_q  [STAGES];
    MULT_FUNC          func_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [PW-1:0]     a_q    [STAGES];
    logic [XLEN-1:0]   b_q    [STAGES];
    logic [PW-1:0]     acc_q  [STAGES];

    MULT_FUNC          func_d [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic [PW-1:0]     a_d    [STAGES];
    logic [XLEN-1:0]   b_d    [STAGES];
    logic [PW-1:0]     acc_d  [STAGES];

    logic stall;

    assign stall    = vld_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // Stage 0 seeds the accumulator with the sign weight of opb (-2^XLEN
    // times opa when opb is negative) plus the lowest opb slice.
    always_comb begin
        func_d[0] = in_func;
        tag_d[0]  = in_tag;
        a_d[0]    = extend_opa(in_func, in_opa);
        b_d[0]    = in_opb;
        acc_d[0]  = (opb_negative(in_func, in_opb) ? ({PW{1'b0}} - (a_d[0] << XLEN)) : {PW{1'b0}})
                  + partial(a_d[0], in_opb, 0);
        for (int k = 1; k < STAGES; k++) begin
            func_d[k] = func_q[k-1];
            tag_d[k]  = tag_q[k-1];
            a_d[k]    = a_q[k-1];
            b_d[k]    = b_q[k-1];
            acc_d[k]  = acc_q[k-1] + partial(a_q[k-1], b_q[k-1], k);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                func_q[k] <= func_d[k];
                tag_q[k]  <= tag_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    always_comb begin
        occupied = 1'b0;
        for (int k = 0; k < STAGES; k++) occupied = occupied | vld_q[k];
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign out_result = (func_q[STAGES-1] == MUL) ? acc_q[STAGES-1][XLEN-1:0]
                                                  : acc_q[STAGES-1][PW-1:XLEN];

endmodule

// File: rtl/mult_stage.sv
// Multi-way RV32M multiplier: WAYS independent pipelined lanes with
// valid/ready handshake, flush and occupancy reporting.
module mult_stage
    import sys_defs::*;
#(
    parameter int WAYS   = `WAYS,
    parameter int XLEN   = `XLEN,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic [WAYS-1:0]                        in_valid,
    output logic [WAYS-1:0]                        in_ready,
    input  logic [WAYS-1:0][$bits(MULT_FUNC)-1:0]  in_func,
    input  logic [WAYS-1:0][XLEN-1:0]              in_opa,
    input  logic [WAYS-1:0][XLEN-1:0]              in_opb,
    input  logic [WAYS-1:0][TAG_W-1:0]             in_tag,
    output logic [WAYS-1:0]                        out_valid,
    input  logic [WAYS-1:0]                        out_ready,
    output logic [WAYS-1:0][XLEN-1:0]              out_result,
    output logic [WAYS-1:0][TAG_W-1:0]             out_tag,
    output logic [WAYS-1:0]                        occupied
);

    for (genvar i = 0; i < WAYS; i++) begin : g_lane
        mult_lane #(
            .XLEN   (XLEN),
            .STAGES (STAGES),
            .TAG_W  (TAG_W)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush),
            .in_valid   (in_valid[i]),
            .in_ready   (in_ready[i]),
            .in_func    (MULT_FUNC'(in_func[i])),
            .in_opa     (in_opa[i]),
            .in_opb     (in_opb[i]),
            .in_tag     (in_tag[i]),
            .out_valid  (out_valid[i]),
            .out_ready  (out_ready[i]),
            .out_result (out_result[i]),
            .out_tag    (out_tag[i]),
            .occupied   (occupied[i])
        );
    end

endmodule

// File: tb/tb_mult_stage.sv
// Bench for mult_stage: directed cases plus randomized traffic checked each
// cycle against a queue-based reference of each lane.
module tb_mult_stage;
    import sys_defs::*;

    localparam int WAYS   = 2;
    localparam int XLEN   = 32;
    localparam int STAGES = 4;
    localparam int TAG_W  = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [WAYS-1:0]             in_valid, in_ready, out_valid, out_ready, occupied;
    logic [WAYS-1:0][1:0]        in_func;
    logic [WAYS-1:0][XLEN-1:0]   in_opa, in_opb, out_result;
    logic [WAYS-1:0][TAG_W-1:0]  in_tag, out_tag;

    always #5 clock = ~clock;

    mult_stage #(
        .WAYS   (WAYS),
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .occupied   (occupied)
    );

    int total  = 0;
    int passed = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference product: extend to 66 bits, multiply, pick a half.
    function automatic logic [31:0] ref_mult(input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        ea = (f == MULHU) ? {34'd0, a} : {{34{a[31]}}, a};
        eb = (f == MUL || f == MULH) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (f == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Per-lane model: in-order queue of pending results; an entry becomes
    // visible once the lane has advanced STAGES times since it was accepted.
    logic [XLEN-1:0]  m_res   [WAYS][$];
    logic [TAG_W-1:0] m_tag   [WAYS][$];
    int               m_stamp [WAYS][$];
    int adv     [WAYS] = '{default: 0};
    int emitted [WAYS] = '{default: 0};
    bit pv, stl;

    always @(negedge clock) begin
        for (int l = 0; l < WAYS; l++) begin
            if (!reset) begin
                check($sformatf("rst_out_valid%0d", l), 64'(out_valid[l]), 64'd0);
                check($sformatf("rst_occupied%0d", l), 64'(occupied[l]), 64'd0);
                check($sformatf("rst_in_ready%0d", l), 64'(in_ready[l]), 64'd1);
                m_res[l].delete();
                m_tag[l].delete();
                m_stamp[l].delete();
            end else begin
                pv = 1'b0;
                if (m_res[l].size() > 0) pv = (adv[l] - m_stamp[l][0]) >= STAGES;
                stl = pv && !out_ready[l];
                check($sformatf("out_valid%0d", l), 64'(out_valid[l]), 64'(pv));
                check($sformatf("occupied%0d", l), 64'(occupied[l]), 64'(m_res[l].size() > 0));
                check($sformatf("in_ready%0d", l), 64'(in_ready[l]), 64'(!stl));
                if (pv) begin
                    check($sformatf("out_result%0d", l), 64'(out_result[l]), 64'(m_res[l][0]));
                    check($sformatf("out_tag%0d", l), 64'(out_tag[l]), 64'(m_tag[l][0]));
                end
                if (flush) begin
                    m_res[l].delete();
                    m_tag[l].delete();
                    m_stamp[l].delete();
                end else if (!stl) begin
                    if (pv) begin
                        void'(m_res[l].pop_front());
                        void'(m_tag[l].pop_front());
                        void'(m_stamp[l].pop_front());
                        emitted[l]++;
                    end
                    adv[l]++;
                    if (in_valid[l]) begin
                        m_res[l].push_back(ref_mult(MULT_FUNC'(in_func[l]), in_opa[l], in_opb[l]));
                        m_tag[l].push_back(in_tag[l]);
                        m_stamp[l].push_back(adv[l] - 1);
                    end
                end
            end
        end
    end

    task automatic run_one(input string name, input MULT_FUNC f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        bit g;
        g = 1'b0;
        in_valid[1] = 1'b1;
        in_func[1]  = f;
        in_opa[1]   = a;
        in_opb[1]   = b;
        in_tag[1]   = 6'h2A;
        for (int c = 1; c <= 12 && !g; c++) begin
            @(posedge clock); #1;
            in_valid[1] = 1'b0;
            if (out_valid[1]) g = 1'b1;
        end
        check({name, "_valid"}, 64'(g), 64'd1);
        check(name, 64'(out_result[1]), 64'(exp));
        check({name, "_model"}, 64'(ref_mult(f, a, b)), 64'(exp));
        @(posedge clock); #1;
    endtask

    int lat, e0, e1;
    bit got, saw, seen;
    int idx [WAYS];
    logic [WAYS-1:0] acc;
    logic [1:0]  t_func [WAYS][8];
    logic [31:0] t_a    [WAYS][8];
    logic [31:0] t_b    [WAYS][8];

    initial begin
        in_valid  = '0;
        out_ready = '1;
        in_func   = '0;
        in_opa    = '0;
        in_opb    = '0;
        in_tag    = '0;

        check("model_mul_1x2", 64'(ref_mult(MUL, 32'd1, 32'd2)), 64'h2);
        check("model_mulh_m1", 64'(ref_mult(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h0);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'h3);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_occupied", 64'(occupied), 64'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Lane 0 latency, tag and occupancy
        in_valid[0] = 1'b1;
        in_func[0]  = MUL;
        in_opa[0]   = 32'd1;
        in_opb[0]   = 32'd2;
        in_tag[0]   = 6'd5;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(posedge clock); #1;
            in_valid = '0;
            if (c == 1) check("t1_occupied_early", 64'(occupied[0]), 64'd1);
            if (out_valid[0]) begin
                got = 1'b1;
                lat = c;
            end
        end
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_result", 64'(out_result[0]), 64'h2);
        check("t1_tag", 64'(out_tag[0]), 64'd5);
        check("t1_occupied", 64'(occupied[0]), 64'd1);
        @(posedge clock); #1;
        check("t1_occupied_after", 64'(occupied[0]), 64'd0);

        // Known products
        run_one("mul_ffffff", MUL,   32'h00FF_FFFF, 32'h00EE_EEEE, 32'hED11_1112);
        run_one("mulhu_ffffff", MULHU, 32'h00FF_FFFF, 32'h00EE_EEEE, 32'h0000_EEEE);
        run_one("mulh_m1",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_one("mulhu_m1",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_one("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_one("mul_m1",    MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // Back-to-back on every lane with a 3-cycle output stall
        for (int l = 0; l < WAYS; l++) begin
            idx[l] = 0;
            for (int i = 0; i < 8; i++) begin
                t_func[l][i] = 2'($urandom_range(0, 3));
                t_a[l][i]    = pick_operand();
                t_b[l][i]    = pick_operand();
            end
        end
        e0  = emitted[0];
        e1  = emitted[1];
        saw = 1'b0;
        for (int cyc = 0; cyc < 40 && (idx[0] < 8 || idx[1] < 8); cyc++) begin
            out_ready = (cyc >= 5 && cyc <= 7) ? 2'b00 : 2'b11;
            for (int l = 0; l < WAYS; l++) begin
                if (idx[l] < 8) begin
                    in_valid[l] = 1'b1;
                    in_func[l]  = t_func[l][idx[l]];
                    in_opa[l]   = t_a[l][idx[l]];
                    in_opb[l]   = t_b[l][idx[l]];
                    in_tag[l]   = 6'(idx[l]);
                end else begin
                    in_valid[l] = 1'b0;
                end
            end
            @(negedge clock);
            if (in_ready != 2'b11) saw = 1'b1;
            acc = in_valid & in_ready;
            @(posedge clock); #1;
            for (int l = 0; l < WAYS; l++) if (acc[l]) idx[l]++;
        end
        in_valid  = '0;
        out_ready = '1;
        repeat (12) @(posedge clock);
        #1;
        check("b2b_stall_seen", 64'(saw), 64'd1);
        check("b2b_lane0_count", 64'(emitted[0] - e0), 64'd8);
        check("b2b_lane1_count", 64'(emitted[1] - e1), 64'd8);

        // Flush with 3 in flight and a colliding request
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            in_func[0]  = MULHU;
            in_opa[0]   = $urandom;
            in_opb[0]   = $urandom;
            in_tag[0]   = 6'(10 + i);
            @(posedge clock); #1;
        end
        flush       = 1'b1;
        in_valid[0] = 1'b1;
        in_tag[0]   = 6'd20;
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = '0;
        check("flush_out_valid", 64'(out_valid), 64'h0);
        check("flush_occupied", 64'(occupied), 64'h0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            if (out_valid != 2'b00) seen = 1'b1;
        end
        check("flush_no_late_result", 64'(seen), 64'd0);

        // Asynchronous reset mid-operation
        in_valid[0] = 1'b1;
        in_func[0]  = MUL;
        in_opa[0]   = 32'd7;
        in_opb[0]   = 32'd9;
        in_tag[0]   = 6'd33;
        @(posedge clock); #1;
        in_valid = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_occupied", 64'(occupied), 64'h0);
        check("arst_in_ready", 64'(in_ready), 64'h3);
        @(posedge clock); #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            if (out_valid != 2'b00) seen = 1'b1;
        end
        check("arst_no_stale_result", 64'(seen), 64'd0);

        // Randomized traffic with backpressure and occasional flush
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int l = 0; l < WAYS; l++) begin
                in_valid[l]  = ($urandom_range(0, 3) != 0);
                in_func[l]   = 2'($urandom_range(0, 3));
                in_opa[l]    = pick_operand();
                in_opb[l]    = pick_operand();
                in_tag[l]    = 6'($urandom);
                out_ready[l] = ($urandom_range(0, 3) != 0);
            end
            flush = ($urandom_range(0, 49) == 0);
            @(posedge clock); #1;
        end
        in_valid  = '0;
        flush     = 1'b0;
        out_ready = '1;
        repeat (10) @(posedge clock);
        #1;
        check("drain_occupied", 64'(occupied), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
